// File: rtl/mem_arbiter_pkg.sv
// Shared constants and state encoding for the main-memory line-port arbiter.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W = 14;
    localparam int ARB_LINE_W = 64;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_I_BUSY = 2'd1,
        ARB_D_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Transaction watchdog: counts busy cycles since the last clear and flags
// the cycle in which the count would reach TIMEOUT.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int                CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flags the TIMEOUT-th enabled cycle, so the command is held exactly TIMEOUT cycles.
    assign expired = en && (count_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the main-memory line port between the I-cache
// and D-cache controllers, with write-back/fill locking and a timeout watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int LINE_W  = ARB_LINE_W,
    parameter int TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_rdy,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_rdy,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              err
);
    arb_state_e        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              d_lock_q, d_lock_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_rdy_q, i_rdy_d;
    logic              d_rdy_q, d_rdy_d;
    logic              err_q, err_d;

    logic busy, grant, pick_d, i_elig, d_elig, expired;

    assign busy = (state_q == ARB_I_BUSY) || (state_q == ARB_D_BUSY);

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (grant),
        .en      (busy),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        d_lock_d  = 1'b0;
        op_we_d   = op_we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_rdy_d   = 1'b0;
        d_rdy_d   = 1'b0;
        err_d     = err_q;
        grant     = 1'b0;
        pick_d    = 1'b0;
        // A requester's request is still up during its own rdy cycle.
        i_elig    = i_re && !i_rdy_q;
        d_elig    = (d_re || d_we) && !d_rdy_q;

        case (state_q)
            ARB_IDLE: begin
                if (d_lock_q && d_re) begin
                    grant  = 1'b1;
                    pick_d = 1'b1;
                end else if (i_elig || d_elig) begin
                    grant    = 1'b1;
                    pick_d   = d_elig && (!i_elig || !last_d_q);
                    last_d_d = pick_d;
                end
                if (grant) begin
                    state_d = pick_d ? ARB_D_BUSY : ARB_I_BUSY;
                    addr_d  = pick_d ? d_addr : i_addr;
                    op_we_d = pick_d && d_we;
                    if (pick_d) begin
                        wdata_d = d_wdata;
                    end
                end
            end
            ARB_I_BUSY, ARB_D_BUSY: begin
                // mem_rdy takes priority over a coincident expiry.
                if (mem_rdy || expired) begin
                    state_d = ARB_IDLE;
                    err_d   = err_q || !mem_rdy;
                    if (state_q == ARB_I_BUSY) begin
                        i_rdy_d   = 1'b1;
                        i_rdata_d = mem_rdy ? mem_rdata : '0;
                    end else begin
                        d_rdy_d   = 1'b1;
                        d_rdata_d = mem_rdy ? mem_rdata : '0;
                        d_lock_d  = op_we_q;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            last_d_q  <= 1'b1;
            d_lock_q  <= 1'b0;
            op_we_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_rdy_q   <= 1'b0;
            d_rdy_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            d_lock_q  <= d_lock_d;
            op_we_q   <= op_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_rdy_q   <= i_rdy_d;
            d_rdy_q   <= d_rdy_d;
            err_q     <= err_d;
        end
    end

    assign mem_re    = busy && !op_we_q;
    assign mem_we    = (state_q == ARB_D_BUSY) && op_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign i_rdy     = i_rdy_q;
    assign d_rdata   = d_rdata_q;
    assign d_rdy     = d_rdy_q;
    assign err       = err_q;

endmodule
